// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and constants for the alarm controller slice
package alarm_pkg;
  localparam int CYCLES_PER_SEC_DEFAULT = 27_000_000;
  localparam int TIMER_W = 4;
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
  typedef enum logic [1:0] {
    ARM_DELAY       = 2'd0,
    DRIVER_DELAY    = 2'd1,
    PASSENGER_DELAY = 2'd2,
    ALARM_ON        = 2'd3
  } interval_sel_t;
endpackage

// File: rtl/one_hz_divider.sv
// one_hz_divider: free-running seconds divider with synchronous phase restart
module one_hz_divider #(
  parameter int CYCLES_PER_SEC = alarm_pkg::CYCLES_PER_SEC_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int CW = $clog2(CYCLES_PER_SEC);
  logic [CW-1:0] cnt_q, cnt_d;
  logic wrap;
  assign wrap = cnt_q == CW'(CYCLES_PER_SEC - 1);
  // a restart re-phases the divider, so the wrap it overrides is not a tick
  assign tick = wrap && !restart;
  // count 0..CYCLES_PER_SEC-1, wrapping or snapping back to 0 on restart
  always_comb cnt_d = (restart || wrap) ? '0 : cnt_q + 1'b1;
  // divider count register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: counts a loaded interval down in seconds and pulses expired
module countdown_timer
  import alarm_pkg::*;
#(
  parameter int CYCLES_PER_SEC = CYCLES_PER_SEC_DEFAULT,
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_timer,
  input  logic         abort,
  input  logic [W-1:0] value,
  output logic         busy,
  output logic         expired,
  output logic [W-1:0] remaining,
  output logic         one_hz
);
  state_t state_q, state_d;
  logic busy_q, busy_d, expired_q, expired_d, one_hz_q, one_hz_d;
  logic [W-1:0] remaining_q, remaining_d;
  logic tick;
  one_hz_divider #(.CYCLES_PER_SEC(CYCLES_PER_SEC)) u_div (
    .clk(clk),
    .reset(reset),
    .restart(start_timer),
    .tick(tick)
  );
  // next state: start beats abort beats tick; expired is a one-cycle pulse
  always_comb begin
    state_d = state_q;
    busy_d = busy_q;
    expired_d = 1'b0;
    remaining_d = remaining_q;
    one_hz_d = tick;
    if (start_timer) begin
      state_d = (value != '0) ? RUN : IDLE;
      busy_d = value != '0;
      expired_d = value == '0;
      remaining_d = value;
    end else if (abort && state_q == RUN) begin
      state_d = IDLE;
      busy_d = 1'b0;
      remaining_d = '0;
    end else if (tick && state_q == RUN && remaining_q != '0) begin
      remaining_d = remaining_q - 1'b1;
      state_d = (remaining_q == W'(1)) ? IDLE : RUN;
      busy_d = remaining_q != W'(1);
      expired_d = remaining_q == W'(1);
    end
  end
  // registered state and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      expired_q <= 1'b0;
      remaining_q <= '0;
      one_hz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      expired_q <= expired_d;
      remaining_q <= remaining_d;
      one_hz_q <= one_hz_d;
    end
  end
  assign busy = busy_q;
  assign expired = expired_q;
  assign remaining = remaining_q;
  assign one_hz = one_hz_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench for countdown_timer at 4 cycles per second
module tb_countdown_timer;
  logic clk = 1'b0;
  logic reset, start_timer, abort;
  logic [3:0] value;
  logic busy, expired, one_hz;
  logic [3:0] remaining;
  logic [6:0] exp_q[$];
  logic [6:0] got, want;
  int total = 0;
  int bad = 0;

  countdown_timer #(.CYCLES_PER_SEC(4), .W(4)) dut (
    .clk(clk),
    .reset(reset),
    .start_timer(start_timer),
    .abort(abort),
    .value(value),
    .busy(busy),
    .expired(expired),
    .remaining(remaining),
    .one_hz(one_hz)
  );

  always #5 clk = ~clk;

  // expected {busy, expired, remaining, one_hz} m edges after a start of v sampled at edge 0
  function automatic logic [6:0] run_exp(int v, int m);
    logic [3:0] r;
    r = (m < 4 * v) ? 4'(v - m / 4) : 4'd0;
    return {m < 4 * v, m == 4 * v, r, m > 0 && m % 4 == 0};
  endfunction

  task automatic test_reset();
    for (int m = 0; m <= 12; m++) exp_q.push_back({2'b00, 4'd0, m > 0 && m % 4 == 0});
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    for (int m = 0; m <= 12; m++) begin
      @(posedge clk);
      @(negedge clk);
      if (m == 0) reset = 1'b0;
      got = {busy, expired, remaining, one_hz};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset m=%0d got(b,e,rem,hz)=%b want=%b", m, got, want);
      end
    end
  endtask

  task automatic test_countdown();
    for (int m = 0; m <= 16; m++) exp_q.push_back(run_exp(3, m));
    @(negedge clk);
    start_timer = 1'b1;
    value = 4'd3;
    for (int m = 0; m <= 16; m++) begin
      @(posedge clk);
      @(negedge clk);
      start_timer = 1'b0;
      got = {busy, expired, remaining, one_hz};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL countdown m=%0d got(b,e,rem,hz)=%b want=%b", m, got, want);
      end
    end
  endtask

  task automatic test_zero();
    for (int m = 0; m <= 5; m++) exp_q.push_back(run_exp(0, m));
    @(negedge clk);
    start_timer = 1'b1;
    value = 4'd0;
    for (int m = 0; m <= 5; m++) begin
      @(posedge clk);
      @(negedge clk);
      start_timer = 1'b0;
      got = {busy, expired, remaining, one_hz};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL zero m=%0d got(b,e,rem,hz)=%b want=%b", m, got, want);
      end
    end
  endtask

  task automatic test_abort();
    for (int m = 0; m <= 40; m++)
      exp_q.push_back(m < 6 ? run_exp(5, m) : {2'b00, 4'd0, m % 4 == 0});
    @(negedge clk);
    start_timer = 1'b1;
    value = 4'd5;
    for (int m = 0; m <= 40; m++) begin
      @(posedge clk);
      @(negedge clk);
      start_timer = 1'b0;
      abort = m == 5;
      got = {busy, expired, remaining, one_hz};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL abort m=%0d got(b,e,rem,hz)=%b want=%b", m, got, want);
      end
    end
  endtask

  task automatic test_restart();
    for (int m = 0; m <= 16; m++) exp_q.push_back(m < 8 ? run_exp(2, m) : run_exp(1, m - 8));
    @(negedge clk);
    start_timer = 1'b1;
    value = 4'd2;
    for (int m = 0; m <= 16; m++) begin
      @(posedge clk);
      @(negedge clk);
      start_timer = m == 7;
      if (m == 7) value = 4'd1;
      got = {busy, expired, remaining, one_hz};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL restart m=%0d got(b,e,rem,hz)=%b want=%b", m, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int m = 0; m <= 13; m++) exp_q.push_back(m < 5 ? run_exp(1, m) : run_exp(2, m - 5));
    @(negedge clk);
    start_timer = 1'b1;
    value = 4'd1;
    for (int m = 0; m <= 13; m++) begin
      @(posedge clk);
      @(negedge clk);
      start_timer = m == 4;
      if (m == 4) value = 4'd2;
      got = {busy, expired, remaining, one_hz};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL back_to_back m=%0d got(b,e,rem,hz)=%b want=%b", m, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int m = 0; m <= 30; m++)
      exp_q.push_back(m < 5 ? run_exp(15, m) : {2'b00, 4'd0, m > 5 && (m - 5) % 4 == 0});
    @(negedge clk);
    start_timer = 1'b1;
    value = 4'd15;
    for (int m = 0; m <= 30; m++) begin
      @(posedge clk);
      @(negedge clk);
      start_timer = 1'b0;
      reset = m == 4;
      got = {busy, expired, remaining, one_hz};
      want = exp_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset_mid m=%0d got(b,e,rem,hz)=%b want=%b", m, got, want);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start_timer = 1'b0;
    abort = 1'b0;
    value = 4'd0;
    test_reset();
    test_countdown();
    test_zero();
    test_abort();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
